// File: rtl/gcd_pkg.sv
// Shared types for the GCD front end: operand width, feeder FSM states and the operand pair record.
package gcd_pkg;

    localparam int GCD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } feed_state_t;

    typedef struct packed {
        logic [GCD_W-1:0] a;
        logic [GCD_W-1:0] b;
    } gcd_pair_t;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Operand-pair FIFO: DEPTH entries of {a,b}, head read combinationally, occupancy counter.
module gcd_pair_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [2*W-1:0]           wr_data,
    output logic [2*W-1:0]           rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [2*W-1:0] mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [AW:0]    count_r;
    logic           push_s;
    logic           pop_s;

    assign full    = (count_r == (AW+1)'(DEPTH));
    assign empty   = (count_r == {(AW+1){1'b0}});
    assign push_s  = push && !full;
    assign pop_s   = pop && !empty;
    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;

    // Storage array; contents need no reset because pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + {{AW{1'b0}}, 1'b1};
            end else if (pop_s && !push_s) begin
                count_r <= count_r - {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/gcd_operand_feeder.sv
// Buffers operand pairs and issues them to the GCD core one job at a time.
// Optional completed-job counter on issued_cnt when GCD_FEED_STATS_EN is defined.
module gcd_operand_feeder
    import gcd_pkg::*;
#(
    parameter int W     = GCD_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_val,
    output logic                     in_rdy,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    output logic                     operands_val,
    output logic [W-1:0]             op_a,
    output logic [W-1:0]             op_b,
    input  logic                     core_ready,
    input  logic                     core_done,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef GCD_FEED_STATS_EN
    ,
    output logic [15:0]              issued_cnt
`endif
);

    feed_state_t    state_r;
    feed_state_t    state_s;
    logic           pop_s;
    logic           push_s;
    logic           full_s;
    logic           empty_s;
    logic [2*W-1:0] head_s;
    logic [W-1:0]   op_a_r;
    logic [W-1:0]   op_b_r;

    assign in_rdy = !full_s;
    assign push_s = in_val && in_rdy;

    gcd_pair_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data ({in_a, in_b}),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (fifo_count)
    );

    // Next-state and pop decode; a pop only happens from IDLE.
    always_comb begin
        state_s = state_r;
        pop_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s && core_ready) begin
                    state_s = ISSUE;
                    pop_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    state_s = DRAIN;
                end else begin
                    state_s = WAIT;
                end
            end
            DRAIN: begin
                if (!core_done) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand registers load only on a pop and hold for the whole job.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a_r <= {W{1'b0}};
            op_b_r <= {W{1'b0}};
        end else if (pop_s) begin
            op_a_r <= head_s[2*W-1:W];
            op_b_r <= head_s[W-1:0];
        end
    end

    assign op_a         = op_a_r;
    assign op_b         = op_b_r;
    assign operands_val = (state_r == ISSUE);

`ifdef GCD_FEED_STATS_EN
    logic [15:0] issued_cnt_r;

    // Counts WAIT->DRAIN transitions, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            issued_cnt_r <= 16'd0;
        end else if ((state_r == WAIT) && core_done) begin
            issued_cnt_r <= issued_cnt_r + 16'd1;
        end
    end

    assign issued_cnt = issued_cnt_r;
`endif

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Directed bench for gcd_operand_feeder: per-cycle vector table plus hand-written corner sequences.
module tb_gcd_operand_feeder;
    import gcd_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_val;
    logic        in_rdy;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        operands_val;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        core_ready;
    logic        core_done;
    logic [2:0]  fifo_count;
`ifdef GCD_FEED_STATS_EN
    logic [15:0] issued_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    gcd_operand_feeder #(.W(16), .DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_val       (in_val),
        .in_rdy       (in_rdy),
        .in_a         (in_a),
        .in_b         (in_b),
        .operands_val (operands_val),
        .op_a         (op_a),
        .op_b         (op_b),
        .core_ready   (core_ready),
        .core_done    (core_done),
        .fifo_count   (fifo_count)
`ifdef GCD_FEED_STATS_EN
        ,
        .issued_cnt   (issued_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       in_val;
        gcd_pair_t  in_p;
        logic       rdy;
        logic       done;
        logic       e_val;
        gcd_pair_t  e_op;
        logic [2:0] e_cnt;
        logic       e_in_rdy;
    } vec_t;

    vec_t vecs [26];

    function automatic vec_t mk(input logic iv, input logic [15:0] a, input logic [15:0] b,
                                input logic rdy, input logic done, input logic ev,
                                input logic [15:0] ea, input logic [15:0] eb,
                                input logic [2:0] ec, input logic er);
        vec_t v;
        v.in_val   = iv;
        v.in_p.a   = a;
        v.in_p.b   = b;
        v.rdy      = rdy;
        v.done     = done;
        v.e_val    = ev;
        v.e_op.a   = ea;
        v.e_op.b   = eb;
        v.e_cnt    = ec;
        v.e_in_rdy = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Outputs are compared at the falling edge; inputs change right after it.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_val = 1'b0;
        core_done = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        in_val = 1'b1;
        in_a = a;
        in_b = b;
        step();
        in_val = 1'b0;
    endtask

    task automatic expect_issue(input string nm, input logic [15:0] ea, input logic [15:0] eb);
        int n = 0;
        while (operands_val !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk({nm, "_val"}, operands_val, 1'b1);
        chk({nm, "_op_a"}, op_a, ea);
        chk({nm, "_op_b"}, op_b, eb);
        step();
        chk({nm, "_pulse_len"}, operands_val, 1'b0);
    endtask

    task automatic finish_job();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        step();
    endtask

    initial begin
        logic seen;
        reset = 1'b1;
        in_val = 1'b0;
        in_a = 16'd0;
        in_b = 16'd0;
        core_ready = 1'b1;
        core_done = 1'b0;
        step();
        step();
        chk("rst_val", operands_val, 1'b0);
        chk("rst_op_a", op_a, 16'd0);
        chk("rst_op_b", op_b, 16'd0);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_in_rdy", in_rdy, 1'b1);
`ifdef GCD_FEED_STATS_EN
        chk("rst_issued", issued_cnt, 16'd0);
`endif
        reset = 1'b0;

        // Single job (27,36), done-in-IDLE ignored, then ordering (48,18),(7,0),(0,5).
        vecs[0]  = mk(1'b1, 16'd27, 16'd36, 1'b1, 1'b0, 1'b0, 16'd0,  16'd0,  3'd1, 1'b1);
        vecs[1]  = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b0, 1'b1, 16'd27, 16'd36, 3'd0, 1'b1);
        vecs[2]  = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 16'd27, 16'd36, 3'd0, 1'b1);
        vecs[3]  = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 16'd27, 16'd36, 3'd0, 1'b1);
        vecs[4]  = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 16'd27, 16'd36, 3'd0, 1'b1);
        vecs[5]  = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 16'd27, 16'd36, 3'd0, 1'b1);
        vecs[6]  = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b1, 1'b0, 16'd27, 16'd36, 3'd0, 1'b1);
        vecs[7]  = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b1, 1'b0, 16'd27, 16'd36, 3'd0, 1'b1);
        vecs[8]  = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 16'd27, 16'd36, 3'd0, 1'b1);
        vecs[9]  = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 16'd27, 16'd36, 3'd0, 1'b1);
        vecs[10] = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b1, 1'b0, 16'd27, 16'd36, 3'd0, 1'b1);
        vecs[11] = mk(1'b1, 16'd48, 16'd18, 1'b1, 1'b0, 1'b0, 16'd27, 16'd36, 3'd1, 1'b1);
        vecs[12] = mk(1'b1, 16'd7,  16'd0,  1'b1, 1'b0, 1'b1, 16'd48, 16'd18, 3'd1, 1'b1);
        vecs[13] = mk(1'b1, 16'd0,  16'd5,  1'b1, 1'b0, 1'b0, 16'd48, 16'd18, 3'd2, 1'b1);
        vecs[14] = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 16'd48, 16'd18, 3'd2, 1'b1);
        vecs[15] = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b1, 1'b0, 16'd48, 16'd18, 3'd2, 1'b1);
        vecs[16] = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 16'd48, 16'd18, 3'd2, 1'b1);
        vecs[17] = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b0, 1'b1, 16'd7,  16'd0,  3'd1, 1'b1);
        vecs[18] = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 16'd7,  16'd0,  3'd1, 1'b1);
        vecs[19] = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b1, 1'b0, 16'd7,  16'd0,  3'd1, 1'b1);
        vecs[20] = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 16'd7,  16'd0,  3'd1, 1'b1);
        vecs[21] = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b0, 1'b1, 16'd0,  16'd5,  3'd0, 1'b1);
        vecs[22] = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 16'd0,  16'd5,  3'd0, 1'b1);
        vecs[23] = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b1, 1'b0, 16'd0,  16'd5,  3'd0, 1'b1);
        vecs[24] = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 16'd0,  16'd5,  3'd0, 1'b1);
        vecs[25] = mk(1'b0, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 16'd0,  16'd5,  3'd0, 1'b1);

        for (int i = 0; i < 26; i++) begin
            in_val     = vecs[i].in_val;
            in_a       = vecs[i].in_p.a;
            in_b       = vecs[i].in_p.b;
            core_ready = vecs[i].rdy;
            core_done  = vecs[i].done;
            step();
            chk($sformatf("vec%0d_val", i), operands_val, vecs[i].e_val);
            chk($sformatf("vec%0d_op_a", i), op_a, vecs[i].e_op.a);
            chk($sformatf("vec%0d_op_b", i), op_b, vecs[i].e_op.b);
            chk($sformatf("vec%0d_count", i), fifo_count, vecs[i].e_cnt);
            chk($sformatf("vec%0d_in_rdy", i), in_rdy, vecs[i].e_in_rdy);
        end
        in_val = 1'b0;
        core_done = 1'b0;
`ifdef GCD_FEED_STATS_EN
        chk("table_issued", issued_cnt, 16'd4);
`endif

        // Fill: one job parked in WAIT, then four more fill the FIFO and a fifth is refused.
        do_reset();
        core_ready = 1'b1;
        push(16'd100, 16'd101);
        in_val = 1'b1; in_a = 16'd1; in_b = 16'd11; step();
        in_a = 16'd2; in_b = 16'd12; step();
        in_a = 16'd3; in_b = 16'd13; step();
        in_a = 16'd4; in_b = 16'd14; step();
        chk("fill_count", fifo_count, 3'd4);
        chk("fill_in_rdy", in_rdy, 1'b0);
        in_a = 16'd5; in_b = 16'd15; step();
        in_val = 1'b0;
        chk("fill_count_5th", fifo_count, 3'd4);
        finish_job();
        expect_issue("fill1", 16'd1, 16'd11);
        finish_job();
        expect_issue("fill2", 16'd2, 16'd12);
        finish_job();
        expect_issue("fill3", 16'd3, 16'd13);
        finish_job();
        expect_issue("fill4", 16'd4, 16'd14);
        finish_job();
        chk("fill_empty", fifo_count, 3'd0);
        step();
        step();
        chk("fill_no_5th", operands_val, 1'b0);

        // Simultaneous push and pop with two entries queued in IDLE.
        do_reset();
        core_ready = 1'b0;
        push(16'd10, 16'd20);
        push(16'd30, 16'd40);
        chk("sim_pre_count", fifo_count, 3'd2);
        chk("sim_pre_val", operands_val, 1'b0);
        core_ready = 1'b1;
        push(16'd50, 16'd60);
        chk("sim_count", fifo_count, 3'd2);
        chk("sim_val", operands_val, 1'b1);
        chk("sim_op_a", op_a, 16'd10);
        chk("sim_op_b", op_b, 16'd20);
        step();
        finish_job();
        expect_issue("sim2", 16'd30, 16'd40);
        finish_job();
        expect_issue("sim3", 16'd50, 16'd60);
        finish_job();
`ifdef GCD_FEED_STATS_EN
        chk("stats_three", issued_cnt, 16'd3);
`endif

        // Reset while a job is in WAIT with three pairs buffered.
        do_reset();
        core_ready = 1'b1;
        push(16'd1, 16'd1);
        in_val = 1'b1; in_a = 16'd2; in_b = 16'd2; step();
        in_a = 16'd3; in_b = 16'd3; step();
        in_a = 16'd4; in_b = 16'd4; step();
        in_val = 1'b0;
        chk("mid_pre_count", fifo_count, 3'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_count", fifo_count, 3'd0);
        chk("mid_val", operands_val, 1'b0);
        chk("mid_op_a", op_a, 16'd0);
        chk("mid_op_b", op_b, 16'd0);
        chk("mid_in_rdy", in_rdy, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (operands_val === 1'b1) seen = 1'b1;
        end
        chk("mid_no_issue", seen, 1'b0);

`ifdef GCD_FEED_STATS_EN
        // Counter wrap from 0xFFFF.
        force dut.issued_cnt_r = 16'hFFFF;
        step();
        release dut.issued_cnt_r;
        step();
        chk("wrap_pre", issued_cnt, 16'hFFFF);
        push(16'd9, 16'd6);
        expect_issue("wrap_job", 16'd9, 16'd6);
        finish_job();
        chk("wrap_issued", issued_cnt, 16'h0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
